// File: rtl/if_id_decode.sv
// ---------------------------------------------------------------------------
// if_id_decode -- IF/ID pipeline register with registered MIPS-subset decode.
//
// A fetched word (if_pc, if_instr) is accepted on the rising clk edge where
// if_valid and if_ready are both 1. Its decoded form appears on the id_* and
// control outputs one cycle later with id_valid=1. The outputs hold while the
// consumer stalls (id_ready=0). flush drops every held word and any word
// offered at the same edge. A bubble (id_valid=0) shows all-zero outputs.
//
// Build option:
//   IF_ID_SKID_EN  defined   -> if_ready is a flop. A one-entry skid buffer
//                               catches the word accepted in the cycle
//                               id_ready fell. Throughput is one word/cycle.
//   IF_ID_SKID_EN  undefined -> no skid; if_ready = id_ready | ~id_valid,
//                               gated off until the first edge after reset.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   if_valid/if_ready        upstream handshake
//   if_pc[31:2], if_instr    fetched word address and instruction
//   flush                    discard all held words
//   id_valid/id_ready        downstream handshake
//   id_pc, id_instr          pass-through of the held word
//   id_rs, id_rt, id_rd      register fields
//   id_imm                   extended immediate (zero/sign/upper per opcode)
//   id_jump_target           {pc[31:28], instr[25:0]}
//   id_branch_target         pc + 1 + sext(imm), word address
//   reg_write ... illegal    one-bit control flags
//   alu_op[2:0]              0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lui
// ---------------------------------------------------------------------------

// Protocol checker: outputs frozen during a stall, bubbles carry zero controls.
module if_id_decode_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        flush,
  input logic        id_valid,
  input logic        id_ready,
  input logic [29:0] pc,
  input logic [31:0] instr,
  input logic [31:0] imm,
  input logic [29:0] jump_target,
  input logic [29:0] branch_target,
  input logic [11:0] ctrl
);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (id_valid && !id_ready && !flush) |=>
      (id_valid && $stable(pc) && $stable(instr) && $stable(imm) &&
       $stable(jump_target) && $stable(branch_target) && $stable(ctrl)));

  a_bubble_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !id_valid |-> (ctrl == 12'h000));

endmodule

module if_id_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:2] if_pc,
  input  logic [31:0] if_instr,
  output logic        if_ready,
  input  logic        flush,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:2] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [31:0] id_imm,
  output logic [31:2] id_jump_target,
  output logic [31:2] id_branch_target,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic        illegal,
  output logic [2:0]  alu_op
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_LUI  = 3'd5;

  // Everything the ID side presents, held in one register.
  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] instr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:2] jump_target;
    logic [31:2] branch_target;
    logic        reg_write;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        illegal;
    logic [2:0]  alu_op;
  } dec_t;

  // Pure decode of one word. Unknown encodings raise only 'illegal'.
  function automatic dec_t decode_word(input logic [31:2] pc, input logic [31:0] instr);
    dec_t        d;
    logic [31:0] sext_imm;
    logic [31:0] zext_imm;
    d        = '0;
    sext_imm = {{16{instr[15]}}, instr[15:0]};
    zext_imm = {16'h0000, instr[15:0]};
    d.pc     = pc;
    d.instr  = instr;
    d.rs     = instr[25:21];
    d.rt     = instr[20:16];
    d.rd     = instr[15:11];
    d.imm    = sext_imm;
    d.jump_target   = {pc[31:28], instr[25:0]};
    // Word-address arithmetic wraps naturally at 30 bits.
    d.branch_target = pc + 30'd1 + sext_imm[29:0];
    case (instr[31:26])
      OP_RTYPE: begin
        case (instr[5:0])
          FN_ADDU: begin d.reg_write = 1'b1; d.reg_dst = 1'b1; d.alu_op = ALU_ADD; end
          FN_SUBU: begin d.reg_write = 1'b1; d.reg_dst = 1'b1; d.alu_op = ALU_SUB; end
          FN_AND:  begin d.reg_write = 1'b1; d.reg_dst = 1'b1; d.alu_op = ALU_AND; end
          FN_OR:   begin d.reg_write = 1'b1; d.reg_dst = 1'b1; d.alu_op = ALU_OR;  end
          FN_SLT:  begin d.reg_write = 1'b1; d.reg_dst = 1'b1; d.alu_op = ALU_SLT; end
          default: d.illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        d.imm       = zext_imm;
        d.alu_op    = ALU_OR;
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
      end
      OP_LUI: begin
        d.imm       = {instr[15:0], 16'h0000};
        d.alu_op    = ALU_LUI;
        d.alu_src   = 1'b1;
        d.reg_write = 1'b1;
      end
      OP_LW: begin
        d.mem_read   = 1'b1;
        d.mem_to_reg = 1'b1;
        d.alu_src    = 1'b1;
        d.reg_write  = 1'b1;
        d.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        d.mem_write = 1'b1;
        d.alu_src   = 1'b1;
        d.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        d.branch = 1'b1;
        d.alu_op = ALU_SUB;
      end
      OP_J: begin
        d.jump = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  dec_t out_r;
  logic out_valid_r;

`ifdef IF_ID_SKID_EN

  logic        skid_valid_r;
  logic [31:2] skid_pc_r;
  logic [31:0] skid_instr_r;
  logic        if_ready_r;
  logic        accept_s;
  logic        load_s;

  // Upstream transfer and output-register reload conditions.
  always_comb begin
    accept_s = if_valid & if_ready_r;
    load_s   = ~out_valid_r | id_ready;
  end

  // Output register, skid entry and registered ready. The skid only fills
  // when the output is stalled; if_ready drops the cycle after it fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_r        <= '0;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 30'd0;
      skid_instr_r <= 32'd0;
      if_ready_r   <= 1'b0;
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      out_r        <= '0;
      skid_valid_r <= 1'b0;
      if_ready_r   <= 1'b1;
    end else if (load_s) begin
      if (skid_valid_r) begin
        // if_ready was low, so nothing new arrives this edge.
        out_r        <= decode_word(skid_pc_r, skid_instr_r);
        out_valid_r  <= 1'b1;
        skid_valid_r <= 1'b0;
      end else if (accept_s) begin
        out_r       <= decode_word(if_pc, if_instr);
        out_valid_r <= 1'b1;
      end else begin
        out_r       <= '0;
        out_valid_r <= 1'b0;
      end
      if_ready_r <= 1'b1;
    end else if (accept_s) begin
      skid_pc_r    <= if_pc;
      skid_instr_r <= if_instr;
      skid_valid_r <= 1'b1;
      if_ready_r   <= 1'b0;
    end else begin
      if_ready_r <= ~skid_valid_r;
    end
  end

  assign if_ready = if_ready_r;

`else

  logic alive_r;
  logic ready_s;
  logic accept_s;

  // Ready passes straight through; alive_r keeps it low until the first
  // edge after reset release.
  always_comb begin
    ready_s  = alive_r & (id_ready | ~out_valid_r);
    accept_s = if_valid & ready_s;
  end

  // Single output register; a stalled word simply holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_r       <= '0;
    end else begin
      alive_r <= 1'b1;
      if (flush) begin
        out_valid_r <= 1'b0;
        out_r       <= '0;
      end else if (accept_s) begin
        out_valid_r <= 1'b1;
        out_r       <= decode_word(if_pc, if_instr);
      end else if (id_ready) begin
        out_valid_r <= 1'b0;
        out_r       <= '0;
      end else begin
        out_valid_r <= out_valid_r;
        out_r       <= out_r;
      end
    end
  end

  assign if_ready = ready_s;

`endif

  assign id_valid         = out_valid_r;
  assign id_pc            = out_r.pc;
  assign id_instr         = out_r.instr;
  assign id_rs            = out_r.rs;
  assign id_rt            = out_r.rt;
  assign id_rd            = out_r.rd;
  assign id_imm           = out_r.imm;
  assign id_jump_target   = out_r.jump_target;
  assign id_branch_target = out_r.branch_target;
  assign reg_write        = out_r.reg_write;
  assign reg_dst          = out_r.reg_dst;
  assign alu_src          = out_r.alu_src;
  assign mem_read         = out_r.mem_read;
  assign mem_write        = out_r.mem_write;
  assign mem_to_reg       = out_r.mem_to_reg;
  assign branch           = out_r.branch;
  assign jump             = out_r.jump;
  assign illegal          = out_r.illegal;
  assign alu_op           = out_r.alu_op;

  logic [11:0] ctrl_s;
  assign ctrl_s = {reg_write, reg_dst, alu_src, mem_read, mem_write,
                   mem_to_reg, branch, jump, illegal, alu_op};

  if_id_decode_chk u_chk (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .pc            (id_pc),
    .instr         (id_instr),
    .imm           (id_imm),
    .jump_target   (id_jump_target),
    .branch_target (id_branch_target),
    .ctrl          (ctrl_s)
  );

endmodule
